alu_op_sequencer: RTL and testbench

//  Issue/complete controller between the decode stage and the ALU. Accepts one op
//  at a time over a valid/ready handshake and drives the ALU A/B/aluop inputs from

---
 rtl/alu_op_sequencer_if.sv | 33 +++
 rtl/alu_op_sequencer.sv | 115 +++++++++++
 tb/tb_alu_op_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Handshake and ALU-operand bundle between decode, the sequencer and the ALU.
// The slave side is the sequencer; the master side is the decode stage, consumer and ALU.
interface alu_op_sequencer_if #(
  parameter int TAG_W = 5
);
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [4:0]       alu_op;
  logic [31:0]      alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  flush, req_valid, req_op, req_a, req_b, req_tag, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_tag, rsp_err, busy
  );

  modport master (
    output flush, req_valid, req_op, req_a, req_b, req_tag, alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_tag, rsp_err, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue/complete controller: holds ALU operands stable for the op's latency,
// captures the result and returns it with its tag over a valid/ready handshake.
module alu_op_sequencer #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8,
  parameter int TAG_W   = 5
) (
  input  logic                ACLK,
  input  logic                RESETN,
  alu_op_sequencer_if.slave   io
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_ld;
  logic [31:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [4:0]       alu_op_q, alu_op_d;
  logic [TAG_W-1:0] tag_q, tag_d, rsp_tag_q, rsp_tag_d;
  logic             err_q, err_d, rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             req_ready, accept, illegal;

  assign req_ready = ~io.flush & ((state_q == IDLE) | ((state_q == DONE) & io.rsp_ready));
  assign accept    = io.req_valid & req_ready;
  assign illegal   = io.req_op > 5'd18;

  // Counter preload is W-1 so the final BUSY cycle is the one with cnt==0.
  always_comb begin
    cnt_ld = '0;
    if (io.req_op >= 5'd10 && io.req_op <= 5'd13)      cnt_ld = MUL_LD;
    else if (io.req_op >= 5'd14 && io.req_op <= 5'd17) cnt_ld = DIV_LD;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tag_d      = tag_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_data_d = err_q ? 32'd0 : io.alu_result;
          rsp_tag_d  = tag_q;
          rsp_err_d  = err_q;
          state_d    = DONE;
        end
      end
      DONE:    if (io.rsp_ready) state_d = IDLE;
      default: ;
    endcase
    // accept already excludes flush; DONE+handshake+accept goes straight to BUSY.
    if (accept) begin
      alu_a_d  = io.req_a;
      alu_b_d  = io.req_b;
      alu_op_d = illegal ? 5'd0 : io.req_op;
      tag_d    = io.req_tag;
      err_d    = illegal;
      cnt_d    = cnt_ld;
      state_d  = BUSY;
    end
    if (io.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge ACLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tag_q      <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tag_q      <= tag_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign io.req_ready = req_ready;
  assign io.alu_a     = alu_a_q;
  assign io.alu_b     = alu_b_q;
  assign io.alu_op    = alu_op_q;
  assign io.rsp_valid = (state_q == DONE);
  assign io.rsp_data  = rsp_data_q;
  assign io.rsp_tag   = rsp_tag_q;
  assign io.rsp_err   = rsp_err_q;
  assign io.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a stub ALU that only produces a correct
// result once operands have been stable for the op's latency, plus directed ops.
module tb_alu_op_sequencer;
  localparam int TAG_W = 5, MUL_LAT = 2, DIV_LAT = 8;

  logic ACLK = 1'b0;
  logic RESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  alu_op_sequencer_if #(.TAG_W(TAG_W)) io();
  alu_op_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .TAG_W(TAG_W)) dut (
    .ACLK(ACLK), .RESETN(RESETN), .io(io)
  );

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               lat;
    int               acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, stable_cnt = 0;
  int last_hs_cyc = -1, last_acc_cyc = -2;
  logic prev_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [4:0] op);
    if (op >= 5'd10 && op <= 5'd13) return MUL_LAT;
    if (op >= 5'd14 && op <= 5'd17) return DIV_LAT;
    return 1;
  endfunction

  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0:    return a + b;
      5'd10:   return a * b;
      5'd14:   return (b != 0) ? 32'($signed(a) / $signed(b)) : 32'hFFFF_FFFF;
      5'd15:   return (b != 0) ? a / b : 32'hFFFF_FFFF;
      5'd17:   return (b != 0) ? a % b : a;
      default: return a ^ b;
    endcase
  endfunction

  // Stub ALU: garbage until operands have been held for the op's pipeline depth.
  always @(posedge ACLK or negedge RESETN)
    if (!RESETN) stable_cnt <= 0;
    else if (io.req_valid && io.req_ready) stable_cnt <= 1;
    else if (stable_cnt < 15) stable_cnt <= stable_cnt + 1;

  assign io.alu_result = (stable_cnt >= lat_of(io.alu_op)) ? alu_f(io.alu_op, io.alu_a, io.alu_b)
                                                           : 32'hDEAD_BEEF;

  always @(posedge ACLK) cyc <= cyc + 1;

  // Monitor: latency on rising rsp_valid, contents on handshake.
  always @(negedge ACLK) begin
    if (!RESETN) begin
      prev_v <= 1'b0;
    end else begin
      if (io.rsp_valid && !prev_v) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 with tag %0d, expected no response", io.rsp_tag);
        end else begin
          chk("rsp_latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
        end
      end
      if (io.rsp_valid && io.rsp_ready && sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("rsp_data", io.rsp_data, mon_e.data);
        chk("rsp_tag", 32'(io.rsp_tag), 32'(mon_e.tag));
        chk("rsp_err", 32'(io.rsp_err), 32'(mon_e.err));
        last_hs_cyc = cyc + 1;
      end
      prev_v <= io.rsp_valid;
    end
  end

  task automatic step();
    @(posedge ACLK); #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp_d,
                       input logic exp_err, input bit push);
    int n = 0;
    logic r;
    io.req_valid = 1'b1; io.req_op = op; io.req_a = a; io.req_b = b; io.req_tag = tag;
    do begin
      r = io.req_ready;
      step();
      n++;
    end while (!r && n < 100);
    io.req_valid = 1'b0;
    if (!r) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: got req_ready=0 for %0d cycles, expected accept", n);
    end else begin
      last_acc_cyc = cyc;
      if (push) sb.push_back('{data: exp_d, tag: tag, err: exp_err, lat: lat_of(op), acc_cyc: cyc});
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (io.busy && n < 50) begin step(); n++; end
    if (io.busy) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_idle_timeout: got busy=1, expected 0", nm);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_req_ready"}, 32'(io.req_ready), 32'd1);
    chk({nm, "_rsp_valid"}, 32'(io.rsp_valid), 32'd0);
    chk({nm, "_busy"},      32'(io.busy),      32'd0);
    chk({nm, "_alu_a"},     io.alu_a,          32'd0);
    chk({nm, "_alu_b"},     io.alu_b,          32'd0);
    chk({nm, "_alu_op"},    32'(io.alu_op),    32'd0);
    chk({nm, "_rsp_data"},  io.rsp_data,       32'd0);
    chk({nm, "_rsp_tag"},   32'(io.rsp_tag),   32'd0);
    chk({nm, "_rsp_err"},   32'(io.rsp_err),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    io.flush = 1'b0; io.req_valid = 1'b0; io.req_op = '0; io.req_a = '0; io.req_b = '0;
    io.req_tag = '0; io.rsp_ready = 1'b0;
    step(); step();
    chk_reset_vals("reset");
    RESETN = 1'b1;
    step();

    // 1: ADD, single-cycle path
    io.rsp_ready = 1'b1;
    issue(5'd0, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0, 1'b1);
    bc = 0;
    while (io.busy && bc < 20) begin bc++; step(); end
    chk("t1_busy_cycles", 32'(bc), 32'd2);

    // 2: MUL, operands stable through BUSY and DONE
    issue(5'd10, 32'hFFFF_FFFF, 32'd2, 5'd9, 32'hFFFF_FFFE, 1'b0, 1'b1);
    for (int i = 0; i <= MUL_LAT; i++) begin
      chk("t2_alu_a", io.alu_a, 32'hFFFF_FFFF);
      chk("t2_alu_b", io.alu_b, 32'd2);
      chk("t2_alu_op", 32'(io.alu_op), 32'd10);
      chk("t2_busy", 32'(io.busy), 32'd1);
      step();
    end
    wait_idle("t2");

    // 3: DIVU then REMU, second accepted on the first's handshake edge
    issue(5'd15, 32'd100, 32'd7, 5'd4, 32'd14, 1'b0, 1'b1);
    issue(5'd17, 32'd100, 32'd7, 5'd5, 32'd2, 1'b0, 1'b1);
    chk("t3_zero_bubble", 32'(last_acc_cyc), 32'(last_hs_cyc));
    wait_idle("t3");

    // 4: DIV with consumer back-pressure
    io.rsp_ready = 1'b0;
    issue(5'd14, 32'd100, 32'd7, 5'd6, 32'd14, 1'b0, 1'b1);
    bc = 0;
    while (!io.rsp_valid && bc < 50) begin bc++; step(); end
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(io.rsp_valid), 32'd1);
      chk("t4_hold_data", io.rsp_data, 32'd14);
      chk("t4_hold_tag", 32'(io.rsp_tag), 32'd6);
      chk("t4_req_ready", 32'(io.req_ready), 32'd0);
      step();
    end
    io.rsp_ready = 1'b1;
    step();
    chk("t4_idle_busy", 32'(io.busy), 32'd0);
    chk("t4_idle_valid", 32'(io.rsp_valid), 32'd0);

    // 5: flush during DIV with a competing request
    issue(5'd14, 32'd50, 32'd5, 5'd7, 32'd0, 1'b0, 1'b0);
    step(); step();
    io.flush = 1'b1; io.req_valid = 1'b1; io.req_op = 5'd0; io.req_tag = 5'd11;
    chk("t5_flush_ready", 32'(io.req_ready), 32'd0);
    step();
    io.flush = 1'b0; io.req_valid = 1'b0;
    chk("t5_flush_busy", 32'(io.busy), 32'd0);
    chk("t5_flush_valid", 32'(io.rsp_valid), 32'd0);
    for (int i = 0; i < 10; i++) step();
    chk("t5_no_rsp", 32'(io.rsp_valid), 32'd0);

    // 5b: async reset in the middle of a MUL
    issue(5'd10, 32'd3, 32'd4, 5'd8, 32'd0, 1'b0, 1'b0);
    chk("t5b_pre_alu_a", io.alu_a, 32'd3);
    #2 RESETN = 1'b0;
    #1 chk_reset_vals("t5b_async");
    step();
    RESETN = 1'b1;
    step(); step(); step();
    chk("t5b_after_busy", 32'(io.busy), 32'd0);

    // 6: illegal op
    issue(5'd25, 32'd9, 32'd9, 5'd2, 32'd0, 1'b1, 1'b1);
    chk("t6_alu_op", 32'(io.alu_op), 32'd0);
    wait_idle("t6");

    step(); step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
